// File: rtl/cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cu_pkg                                                                     |
// | Shared encodings for the pipelined control unit: opcodes, functs, ALU     |
// | control codes, ALUOp classes and the multiply sequencer state type.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b001000;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic branch;
    logic bne_type;
    logic illegal;
  } ctrl_t;

endpackage : cu_pkg
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cu_decode                                                                  |
// | Combinational instruction -> control-word decoder.                         |
// | Define CU_SLT_EN to decode SLT (funct 101010) and SLTI (opcode 001010).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cu_decode
  import cu_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [INSTR_W-1:0]    i_instr,
  output ctrl_t                 o_ctrl,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_is_mul
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  ctrl_t      w_main;
  aluop_e     w_aluop;
  logic       w_op_bad;
  logic [3:0] w_alu_raw;
  logic       w_fn_bad;
  logic       w_fn_mul;

  assign w_opcode = i_instr[INSTR_W-1 -: 6];
  assign w_funct  = i_instr[5:0];

  always_comb begin
    w_main   = '0;
    w_aluop  = ALUOP_ADD;
    w_op_bad = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_main.reg_write = 1'b1;
        w_main.reg_dst   = 1'b1;
        w_aluop          = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        w_main.branch = 1'b1;
        w_aluop       = ALUOP_SUB;
      end
      OP_BNE: begin
        w_main.branch   = 1'b1;
        w_main.bne_type = 1'b1;
        w_aluop         = ALUOP_SUB;
      end
      OP_ADDI: begin
        w_main.reg_write = 1'b1;
        w_main.alu_src   = 1'b1;
      end
      OP_LW: begin
        w_main.reg_write  = 1'b1;
        w_main.mem_to_reg = 1'b1;
        w_main.alu_src    = 1'b1;
      end
      OP_SW: begin
        w_main.mem_write = 1'b1;
        w_main.alu_src   = 1'b1;
      end
`ifdef CU_SLT_EN
      OP_SLTI: begin
        w_main.reg_write = 1'b1;
        w_main.alu_src   = 1'b1;
        w_aluop          = ALUOP_SLT;
      end
`endif
      default: w_op_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_raw = ALU_ADD;
    w_fn_bad  = 1'b0;
    w_fn_mul  = 1'b0;
    case (w_aluop)
      ALUOP_ADD: w_alu_raw = ALU_ADD;
      ALUOP_SUB: w_alu_raw = ALU_SUB;
      ALUOP_SLT: w_alu_raw = ALU_SLT;
      ALUOP_FUNCT: begin
        case (w_funct)
          FN_ADD: w_alu_raw = ALU_ADD;
          FN_SUB: w_alu_raw = ALU_SUB;
          FN_AND: w_alu_raw = ALU_AND;
          FN_OR:  w_alu_raw = ALU_OR;
`ifdef CU_SLT_EN
          FN_SLT: w_alu_raw = ALU_SLT;
`endif
          FN_MUL: begin
            w_alu_raw = ALU_MUL;
            w_fn_mul  = 1'b1;
          end
          default: begin
            w_alu_raw = ALU_AND;
            w_fn_bad  = 1'b1;
          end
        endcase
      end
      default: w_alu_raw = ALU_ADD;
    endcase
  end

  // Any undecodable encoding collapses to a word with only the illegal flag set.
  always_comb begin
    o_ctrl     = w_main;
    o_alu_ctrl = ALU_CTRL_W'(w_alu_raw);
    o_is_mul   = w_fn_mul;
    if (w_op_bad || w_fn_bad) begin
      o_ctrl         = '0;
      o_ctrl.illegal = 1'b1;
      o_alu_ctrl     = '0;
      o_is_mul       = 1'b0;
    end
  end

endmodule : cu_decode
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_control_unit                                                     |
// | D->E control register with valid/stall/flush and a multicycle-multiply     |
// | sequencer. Define CU_SLT_EN to add SLT/SLTI decode.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instrD,
  input  logic                  validD,
  input  logic                  stallE,
  input  logic                  flushE,
  output logic                  regWriteE,
  output logic                  memToRegE,
  output logic                  memWriteE,
  output logic                  ALUSrcE,
  output logic                  regDstE,
  output logic                  branchE,
  output logic                  bneTypeE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  validE,
  output logic                  illegalE,
  output logic                  mulBusy,
  output logic                  mulDoneE
);

  localparam int             c_cnt_w    = 4;
  localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_CYCLES - 1);
  localparam bit             c_multi    = (MUL_CYCLES > 1);

  ctrl_t                 w_dec_ctrl;
  logic [ALU_CTRL_W-1:0] w_dec_alu;
  logic                  w_dec_mul;
  logic                  w_hold;
  logic                  w_load_mul;

  ctrl_t                 r_ctrl;
  logic [ALU_CTRL_W-1:0] r_alu;
  logic                  r_valid;

  mul_state_e            r_state;
  mul_state_e            w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic                  r_single;
  logic                  w_single_nxt;

  cu_decode #(
    .INSTR_W    (INSTR_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_decode (
    .i_instr    (instrD),
    .o_ctrl     (w_dec_ctrl),
    .o_alu_ctrl (w_dec_alu),
    .o_is_mul   (w_dec_mul)
  );

  assign mulBusy    = (r_state == ST_BUSY);
  assign w_hold     = stallE || mulBusy;
  assign w_load_mul = !flushE && !w_hold && validD && w_dec_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_valid <= 1'b0;
    end else if (flushE) begin
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_valid <= validD;
      r_ctrl  <= validD ? w_dec_ctrl : '0;
      r_alu   <= validD ? w_dec_alu : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_single <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_single <= w_single_nxt;
    end
  end

  // The counter runs even while stallE holds the E register.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_single_nxt = 1'b0;
    if (flushE) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_mul) begin
            if (c_multi) begin
              w_state_nxt = ST_BUSY;
              w_cnt_nxt   = c_mul_load;
            end else begin
              w_single_nxt = 1'b1;
            end
          end
        end
        ST_BUSY: begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A flush in the final cycle aborts the multiply, so the pulse is suppressed.
  assign mulDoneE = !flushE && ((mulBusy && (r_cnt == c_cnt_w'(1))) || r_single);

  assign regWriteE   = r_ctrl.reg_write;
  assign memToRegE   = r_ctrl.mem_to_reg;
  assign memWriteE   = r_ctrl.mem_write;
  assign ALUSrcE     = r_ctrl.alu_src;
  assign regDstE     = r_ctrl.reg_dst;
  assign branchE     = r_ctrl.branch;
  assign bneTypeE    = r_ctrl.bne_type;
  assign illegalE    = r_ctrl.illegal;
  assign ALUControlE = r_alu;
  assign validE      = r_valid;

endmodule : pipelined_control_unit
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_control_unit                                                  |
// | Scoreboard bench: driver queues cycle-tagged expected outputs, a negedge   |
// | monitor pops and compares them. Honours CU_SLT_EN for expected values.     |
// | Revision: 1.1                                                              |
// +----------------------------------------------------------------------------+
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instrD = 32'h0;
    logic        validD = 1'b0;
    logic        stallE = 1'b0;
    logic        flushE = 1'b0;
    logic        regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, branchE, bneTypeE;
    logic [3:0]  ALUControlE;
    logic        validE, illegalE, mulBusy, mulDoneE;

    pipelined_control_unit #(
        .INSTR_W    (32),
        .ALU_CTRL_W (4),
        .MUL_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instrD      (instrD),
        .validD      (validD),
        .stallE      (stallE),
        .flushE      (flushE),
        .regWriteE   (regWriteE),
        .memToRegE   (memToRegE),
        .memWriteE   (memWriteE),
        .ALUSrcE     (ALUSrcE),
        .regDstE     (regDstE),
        .branchE     (branchE),
        .bneTypeE    (bneTypeE),
        .ALUControlE (ALUControlE),
        .validE      (validE),
        .illegalE    (illegalE),
        .mulBusy     (mulBusy),
        .mulDoneE    (mulDoneE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests = 0;
    int          fails = 0;
    int          q_cyc[$];
    logic [14:0] q_word[$];
    string       q_name[$];

    // Field order: rw mr mw as rd br bn alu[3:0] v il mb md
    function automatic logic [14:0] cw(input bit rw, mr, mw, as, rd, br, bn,
                                       input logic [3:0] alu,
                                       input bit v, il, mb, md);
        return {rw, mr, mw, as, rd, br, bn, alu, v, il, mb, md};
    endfunction

    logic [14:0] got;
    assign got = {regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, branchE, bneTypeE,
                  ALUControlE, validE, illegalE, mulBusy, mulDoneE};

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int          ec;
            logic [14:0] ew;
            string       en;
            ec = q_cyc.pop_front();
            ew = q_word.pop_front();
            en = q_name.pop_front();
            tests = tests + 1;
            if (ec != cyc || got !== ew) begin
                fails = fails + 1;
                $display("FAIL %s: cycle %0d got %b expected %b (due cycle %0d)", en, cyc, got, ew, ec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $finish;
    end

    task automatic expect_at(input int c, input logic [14:0] w, input string n);
        q_cyc.push_back(c);
        q_word.push_back(w);
        q_name.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input bit v);
        instrD = i;
        validD = v;
    endtask

    task automatic send(input logic [31:0] i, input bit v, input logic [14:0] w, input string n);
        issue(i, v);
        expect_at(cyc + 1, w, n);
        tick();
    endtask

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_AND  = 32'h00221824;
    localparam logic [31:0] I_OR   = 32'h00221825;
    localparam logic [31:0] I_BADF = 32'h00221821;
    localparam logic [31:0] I_SLT  = 32'h0022182A;
    localparam logic [31:0] I_MUL  = 32'h00221818;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_BNE  = 32'h20220003;
    localparam logic [31:0] I_ADDI = 32'h24010005;
    localparam logic [31:0] I_SLTI = 32'h28220005;
    localparam logic [31:0] I_BADO = 32'hFC000000;

    logic [14:0] w_zero, w_add, w_mul_b, w_mul_d, w_mul_i, w_ill;

    initial begin
        int c0;
        w_zero  = '0;
        w_add   = cw(1,0,0,0,1,0,0,4'b0010,1,0,0,0);
        w_mul_b = cw(1,0,0,0,1,0,0,4'b1111,1,0,1,0);
        w_mul_d = cw(1,0,0,0,1,0,0,4'b1111,1,0,1,1);
        w_mul_i = cw(1,0,0,0,1,0,0,4'b1111,1,0,0,0);
        w_ill   = cw(0,0,0,0,0,0,0,4'b0000,1,1,0,0);

        issue(I_ADD, 1'b1);
        tick();
        tick();
        tests = tests + 1;
        if (got !== 15'b0) begin
            fails = fails + 1;
            $display("FAIL reset_state: got %b expected all zero", got);
        end
        expect_at(cyc, w_zero, "reset");
        rst_n = 1'b1;
        expect_at(cyc + 1, w_add, "add_after_reset");
        tick();

        send(I_LW,   1, cw(1,1,0,1,0,0,0,4'b0010,1,0,0,0), "lw");
        send(I_SW,   1, cw(0,0,1,1,0,0,0,4'b0010,1,0,0,0), "sw");
        send(I_BEQ,  1, cw(0,0,0,0,0,1,0,4'b0110,1,0,0,0), "beq");
        send(I_ADDI, 1, cw(1,0,0,1,0,0,0,4'b0010,1,0,0,0), "addi");
        send(I_BNE,  1, cw(0,0,0,0,0,1,1,4'b0110,1,0,0,0), "bne");
        send(I_SUB,  1, cw(1,0,0,0,1,0,0,4'b0110,1,0,0,0), "sub");
        send(I_AND,  1, cw(1,0,0,0,1,0,0,4'b0000,1,0,0,0), "and");
        send(I_OR,   1, cw(1,0,0,0,1,0,0,4'b0001,1,0,0,0), "or");
        send(I_BADF, 1, w_ill, "illegal_funct");
        send(I_BADO, 1, w_ill, "illegal_opcode");
`ifdef CU_SLT_EN
        send(I_SLT,  1, cw(1,0,0,0,1,0,0,4'b0111,1,0,0,0), "slt");
        send(I_SLTI, 1, cw(1,0,0,1,0,0,0,4'b0111,1,0,0,0), "slti");
`else
        send(I_SLT,  1, w_ill, "slt_disabled");
        send(I_SLTI, 1, w_ill, "slti_disabled");
`endif

        // Full multiply: busy 3 cycles, done on the 3rd, ADD held until busy falls
        c0 = cyc;
        issue(I_MUL, 1'b1);
        expect_at(c0 + 1, w_mul_b, "mul_busy1");
        expect_at(c0 + 2, w_mul_b, "mul_busy2");
        expect_at(c0 + 3, w_mul_d, "mul_done");
        expect_at(c0 + 4, w_mul_i, "mul_tail");
        expect_at(c0 + 5, w_add,   "add_after_mul");
        tick();
        issue(I_ADD, 1'b1);
        repeat (4) tick();

        // Flush in the 2nd busy cycle
        c0 = cyc;
        issue(I_MUL, 1'b1);
        expect_at(c0 + 1, w_mul_b, "flush_busy1");
        expect_at(c0 + 2, w_mul_b, "flush_busy2");
        expect_at(c0 + 3, w_zero,  "flush_bubble");
        expect_at(c0 + 4, w_add,   "flush_next_add");
        tick();
        issue(I_ADD, 1'b1);
        tick();
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        tick();

        // Async reset mid-multiply
        c0 = cyc;
        issue(I_MUL, 1'b1);
        expect_at(c0 + 1, w_mul_b, "rst_busy1");
        expect_at(c0 + 2, w_zero,  "rst_async");
        expect_at(c0 + 3, w_zero,  "rst_held");
        expect_at(c0 + 4, w_add,   "rst_next_add");
        tick();
        issue(I_ADD, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Stall for 2 cycles while instrD changes, then a validD=0 bubble
        c0 = cyc;
        issue(I_ADD, 1'b1);
        expect_at(c0 + 1, w_add, "stall_load");
        expect_at(c0 + 2, w_add, "stall_hold1");
        expect_at(c0 + 3, w_add, "stall_hold2");
        expect_at(c0 + 4, cw(0,0,0,0,0,1,0,4'b0110,1,0,0,0), "stall_release_beq");
        expect_at(c0 + 5, w_zero, "valid_bubble");
        tick();
        stallE = 1'b1;
        issue(I_LW, 1'b1);
        tick();
        issue(I_SW, 1'b1);
        tick();
        stallE = 1'b0;
        issue(I_BEQ, 1'b1);
        tick();
        issue(I_LW, 1'b0);
        tick();

        issue(32'h0, 1'b0);
        repeat (3) tick();
        while (q_name.size() > 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL expired: expectation %s due cycle %0d never checked", q_name[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_word.pop_front());
            void'(q_name.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipelined_control_unit
`default_nettype wire
